enc_fifo_buffer: RTL and testbench
==================================

ENC_FIFO_BUFFER -- requirements
Module: enc_fifo_buffer

Interface
REQ-001 Parameter DATA_W, default 8, is the width of one encoded data word.
REQ-002 Parameter DEPTH, default 16, is the number of storage entries and SHALL be a power of two, 2 to 256.
REQ-003 Parameter ADDR_W, default 4, is the pointer width and SHALL equal log2(DEPTH).
REQ-004 Parameter LOAD_COUNT, default 16, is the number of accepted writes that completes one load, range 1 to 2^16-1.
REQ-005 Port clock, input, 1, is the system clock; all state SHALL change on its rising edge only.
REQ-006 Port reset, input, 1, is the reset: asynchronous, active-high.
REQ-007 Port we, input, 1, is the write enable from the upstream write-control FSM.
REQ-008 Port din, input, DATA_W, is the write data, sampled when a write is accepted.
REQ-009 Port re, input, 1, is the read request from the downstream consumer.
REQ-010 Port dout, output, DATA_W, is the registered read data.
REQ-011 Port valid, output, 1, is a one-cycle strobe marking dout as new.
REQ-012 Port full, output, 1, is high when occupancy equals DEPTH.
REQ-013 Port empty, output, 1, is high when occupancy equals 0.
REQ-014 Port level, output, ADDR_W+1, is the current occupancy, 0 to DEPTH.
REQ-015 Port count_complete, output, 1, is the load-done flag returned to the write-control FSM.
REQ-016 Port overflow, output, 1, is the sticky flag for a write attempted while full.

Function
REQ-017 A write SHALL be accepted in a cycle when we=1 and full=0, storing din at the write pointer and incrementing the write pointer modulo DEPTH.
REQ-018 A read SHALL be accepted in a cycle when re=1 and empty=0, loading dout from the read pointer and incrementing the read pointer modulo DEPTH.
REQ-019 Read latency SHALL be one cycle: dout and valid=1 appear on the edge that accepts the read, and valid=0 on every cycle with no accepted read.
REQ-020 dout SHALL hold its last value when no read is accepted.
REQ-021 full and empty SHALL be decoded from the registered level; acceptance SHALL use the flag values present at the start of the cycle.
REQ-022 On simultaneous accepted read and write, level SHALL be unchanged and both pointers SHALL advance.
REQ-023 When full with we=1 and re=1, the read SHALL be accepted, the write SHALL be rejected, and overflow SHALL set.
REQ-024 When empty with we=1 and re=1, the write SHALL be accepted, the read SHALL be ignored, and valid SHALL stay 0.
REQ-025 A read with re=1 while empty SHALL change no state.
REQ-026 Data SHALL leave the buffer in write order; a write SHALL be readable no earlier than the cycle after it is accepted.
REQ-027 An internal 16-bit load counter SHALL increment on each accepted write and SHALL saturate at LOAD_COUNT.
REQ-028 count_complete SHALL go high on the edge at which the load counter reaches LOAD_COUNT and SHALL stay high until reset.
REQ-029 Writes after count_complete=1 SHALL still be accepted into storage if not full; they do not advance the counter.
REQ-030 overflow SHALL set on any cycle with we=1 and full=1, and SHALL stay high until reset.

Reset
REQ-031 While reset=1, the block SHALL hold: pointers=0, level=0, empty=1, full=0, dout=0, valid=0, count_complete=0, overflow=0, load counter=0.
REQ-032 Storage array contents SHALL NOT be reset; reads after reset return only data written after reset.
REQ-033 A reset asserted mid-load SHALL discard all buffered words and restart the load count from 0.

Verification
REQ-034 Reset, then write 0x11,0x22,0x33 on 3 cycles -> level=3, empty=0; then re for 3 cycles -> dout 0x11,0x22,0x33, each with a valid pulse one cycle after its read.
REQ-035 Write 16 words with no reads (DEPTH=16) -> full=1, level=16; a 17th we -> rejected, overflow=1, level=16.
REQ-036 From full, we=1 and re=1 together -> oldest word read, write rejected, level=15, overflow=1.
REQ-037 From empty, we=1 and re=1 together -> level=1, valid=0; next cycle re -> dout=written word, valid=1.
REQ-038 LOAD_COUNT=16 with interleaved reads, 16 accepted writes -> count_complete rises on the 16th write edge and stays high; writes 17-20 are stored and count_complete stays 1.
REQ-039 Assert reset asynchronously after 8 writes -> all outputs take their REQ-031 values immediately; after release, re -> valid stays 0.

Source files
------------

// File: rtl/enc_fifo_buffer.sv
// Encoded-word FIFO with a registered read port, occupancy flags and a
// load counter that tells the upstream write-control FSM when a load is done.
module enc_fifo_buffer #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int LOAD_COUNT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  input  logic              re,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              count_complete,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [15:0]     LOAD_TGT = 16'(LOAD_COUNT);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic [15:0]       load_cnt_q, load_cnt_d;
  logic              count_complete_q, count_complete_d;
  logic              overflow_q, overflow_d;

  logic wr_acc;
  logic rd_acc;

  // Flags come from the registered level, so acceptance sees start-of-cycle state.
  assign full   = (level_q == DEPTH_L);
  assign empty  = (level_q == '0);
  assign wr_acc = we & ~full;
  assign rd_acc = re & ~empty;

  always_comb begin
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    level_d          = level_q;
    dout_d           = dout_q;
    valid_d          = 1'b0;
    load_cnt_d       = load_cnt_q;
    count_complete_d = count_complete_q;
    overflow_d       = overflow_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      dout_d   = mem[rd_ptr_q];
      valid_d  = 1'b1;
    end

    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: level_d = level_q;
    endcase

    // Counter saturates at the target; later writes still land in storage.
    if (wr_acc && (load_cnt_q != LOAD_TGT)) begin
      load_cnt_d = load_cnt_q + 16'd1;
    end
    if (load_cnt_d == LOAD_TGT) begin
      count_complete_d = 1'b1;
    end

    if (we && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      level_q          <= '0;
      dout_q           <= '0;
      valid_q          <= 1'b0;
      load_cnt_q       <= '0;
      count_complete_q <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      level_q          <= level_d;
      dout_q           <= dout_d;
      valid_q          <= valid_d;
      load_cnt_q       <= load_cnt_d;
      count_complete_q <= count_complete_d;
      overflow_q       <= overflow_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers guard stale contents.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= din;
    end
  end

  assign dout           = dout_q;
  assign valid          = valid_q;
  assign level          = level_q;
  assign count_complete = count_complete_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_enc_fifo_buffer.sv
// Directed bench for enc_fifo_buffer: fill/drain order, full/empty corner
// cases, load-count completion and asynchronous reset.
module tb_enc_fifo_buffer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              we    = 1'b0;
  logic              re    = 1'b0;
  logic [DATA_W-1:0] din   = '0;
  logic [DATA_W-1:0] dout;
  logic              valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              count_complete;
  logic              overflow;

  int n_cmp = 0;
  int n_bad = 0;

  enc_fifo_buffer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LOAD_COUNT(16)
  ) dut (
    .clock(clock), .reset(reset), .we(we), .din(din), .re(re),
    .dout(dout), .valid(valid), .full(full), .empty(empty),
    .level(level), .count_complete(count_complete), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, then sample 1 time unit after the next rising edge.
  task automatic step(input logic w, input logic r, input logic [DATA_W-1:0] d);
    we  = w;
    re  = r;
    din = d;
    @(posedge clock);
    #1;
    $display("t=%0t we=%0b re=%0b din=%02h | dout=%02h valid=%0b level=%0d full=%0b empty=%0b cc=%0b ovf=%0b",
             $time, w, r, d, dout, valid, level, full, empty, count_complete, overflow);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"},  32'(full),  32'd0);
    check({tag, "_dout"},  32'(dout),  32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_cc"},    32'(count_complete), 32'd0);
    check({tag, "_ovf"},   32'(overflow), 32'd0);
  endtask

  // Called right after a sample point (edge+1); reset pulses between edges.
  task automatic pulse_reset();
    we = 1'b0;
    re = 1'b0;
    #1 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  initial begin
    // Power-on reset
    #12;
    check_reset_state("por");
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Three writes then three reads, in order
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    check("w3_level", 32'(level), 32'd3);
    check("w3_empty", 32'(empty), 32'd0);
    check("w3_valid", 32'(valid), 32'd0);
    step(1'b0, 1'b1, 8'h00);
    check("r1_dout", 32'(dout), 32'h11);
    check("r1_valid", 32'(valid), 32'd1);
    step(1'b0, 1'b1, 8'h00);
    check("r2_dout", 32'(dout), 32'h22);
    step(1'b0, 1'b1, 8'h00);
    check("r3_dout", 32'(dout), 32'h33);
    check("r3_valid", 32'(valid), 32'd1);
    check("r3_empty", 32'(empty), 32'd1);
    // Read while empty changes nothing; dout holds
    step(1'b0, 1'b1, 8'h00);
    check("re_empty_valid", 32'(valid), 32'd0);
    check("re_empty_dout", 32'(dout), 32'h33);
    check("re_empty_level", 32'(level), 32'd0);

    // Fill to full; load count completes on the 16th accepted write
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(8'hA0 + i));
      if (i == 14) check("fill15_cc", 32'(count_complete), 32'd0);
      if (i == 15) check("fill16_cc", 32'(count_complete), 32'd1);
    end
    check("full_flag", 32'(full), 32'd1);
    check("full_level", 32'(level), 32'd16);
    check("full_ovf0", 32'(overflow), 32'd0);
    step(1'b1, 1'b0, 8'hEE);
    check("w17_ovf", 32'(overflow), 32'd1);
    check("w17_level", 32'(level), 32'd16);
    // Full with we and re: read wins, write rejected
    step(1'b1, 1'b1, 8'hEF);
    check("fullrw_dout", 32'(dout), 32'hA0);
    check("fullrw_valid", 32'(valid), 32'd1);
    check("fullrw_level", 32'(level), 32'd15);
    check("fullrw_ovf", 32'(overflow), 32'd1);
    check("fullrw_full", 32'(full), 32'd0);
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("drain%0d_dout", i), 32'(dout), 32'(8'hA0 + i));
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_ovf_sticky", 32'(overflow), 32'd1);
    check("drain_cc_sticky", 32'(count_complete), 32'd1);

    // Empty with we and re: write wins, read ignored
    step(1'b1, 1'b1, 8'h5A);
    check("emptyrw_level", 32'(level), 32'd1);
    check("emptyrw_valid", 32'(valid), 32'd0);
    step(1'b0, 1'b1, 8'h00);
    check("emptyrw_dout", 32'(dout), 32'h5A);
    check("emptyrw_valid2", 32'(valid), 32'd1);
    check("emptyrw_level2", 32'(level), 32'd0);

    // Interleaved write+read stream, 20 accepted writes
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'(i + 1));
      check($sformatf("il%0d_level", i), 32'(level), 32'd1);
      check($sformatf("il%0d_cc", i), 32'(count_complete), (i >= 15) ? 32'd1 : 32'd0);
      if (i >= 1) check($sformatf("il%0d_dout", i), 32'(dout), 32'(i));
      else        check("il0_valid", 32'(valid), 32'd0);
    end
    step(1'b0, 1'b1, 8'h00);
    check("il_last_dout", 32'(dout), 32'd20);

    // Asynchronous reset mid-load
    pulse_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    check("mid_level", 32'(level), 32'd8);
    we = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_reset_state("async");
    #1 reset = 1'b0;
    step(1'b0, 1'b1, 8'h00);
    check("post_rst_valid", 32'(valid), 32'd0);
    check("post_rst_empty", 32'(empty), 32'd1);
    check("post_rst_dout", 32'(dout), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
